booth_pp_gen: RTL and testbench

- Producer side of the multiplier's partial-product path.
- Takes a 32x32 multiply request and radix-4 Booth-encodes the multiplier into 17 partial products.
- Transposes those products into 64 per-column 17-bit bundles that feed the column compressor slices, one bundle per slice.
- Also emits the 17 Booth negate bits that the compressor carry-in and final adder consume.
- Two-stage pipeline with valid/ready handshake on both sides; flushable by the pipeline's cancel.

---
 rtl/booth_pp_gen_pkg.sv | 38 +++
 rtl/booth_sel.sv | 48 ++++
 rtl/booth_pp_gen.sv | 113 +++++++++++
 tb/tb_booth_pp_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pp_gen_pkg.sv
// Shared definitions for the Booth partial-product generator.
// Holds the geometry constants, the decoded Booth operation type with its
// group decoder, and the column-major index helper used by the transpose.
package booth_pp_gen_pkg;

  localparam int NPP   = 17;  // radix-4 groups for a 34-bit extended multiplier
  localparam int PW    = 64;  // product width and column count
  localparam int COL_W = 17;  // bits per column bundle (one per partial product)
  localparam int XW    = 34;  // operand width after signed/unsigned extension

  // Multiple of x_e selected by one Booth group.
  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_PX   = 3'd1,
    OP_P2X  = 3'd2,
    OP_MX   = 3'd3,
    OP_M2X  = 3'd4
  } booth_op_t;

  // Group is {y[2k+1], y[2k], y[2k-1]}.
  function automatic booth_op_t booth_decode(input logic [2:0] grp);
    booth_op_t op;
    case (grp)
      3'b001, 3'b010: op = OP_PX;
      3'b011:         op = OP_P2X;
      3'b100:         op = OP_M2X;
      3'b101, 3'b110: op = OP_MX;
      default:        op = OP_ZERO;  // 000 and 111
    endcase
    return op;
  endfunction

  // Flat bit position of bit j of partial product k in the column-major bus.
  function automatic int col_idx(input int j, input int k);
    return COL_W * j + k;
  endfunction

endpackage

// File: rtl/booth_sel.sv
// One Booth row selector.
// Decodes a 3-bit multiplier group and produces the selected multiple of x_e,
// sign-extended to the product width, bit-inverted when the multiple is
// negative, and shifted left by SHIFT.
// Ports:
//   grp   - Booth group {y[2k+1], y[2k], y[2k-1]}
//   x_e   - 34-bit extended multiplicand
//   row   - pre-shifted partial product (ones' complement form when neg=1)
//   neg   - row is inverted and needs +1 at bit SHIFT
module booth_sel import booth_pp_gen_pkg::*; #(
  parameter int SHIFT = 0
) (
  input  logic [2:0]    grp,
  input  logic [XW-1:0] x_e,
  output logic [PW-1:0] row,
  output logic          neg
);

  booth_op_t     op;
  logic [PW-1:0] x_w;
  logic [PW-1:0] mag;
  logic [PW-1:0] row_pre;

  always_comb begin
    op      = booth_decode(grp);
    x_w     = {{(PW - XW){x_e[XW-1]}}, x_e};
    mag     = '0;
    neg     = 1'b0;
    case (op)
      OP_PX:   mag = x_w;
      OP_P2X:  mag = x_w << 1;
      OP_MX: begin
        mag = x_w;
        neg = 1'b1;
      end
      OP_M2X: begin
        mag = x_w << 1;
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    // Inverting before the shift leaves zeros below SHIFT, so the +1 carried
    // by neg lands exactly at bit SHIFT and completes the two's complement.
    row_pre = neg ? ~mag : mag;
    row     = row_pre << SHIFT;
  end

endmodule

// File: rtl/booth_pp_gen.sv
// Booth partial-product generator, producer side of the multiplier.
// S1 registers the request; S2 registers the 17 Booth rows transposed into
// 64 column bundles of 17 bits plus the per-row negate bits.
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   in_valid/in_ready    - request handshake; is_signed, x, y are the request
//   cancel               - flushes every in-flight request
//   out_valid/out_ready  - column data handshake
//   pp_cols              - pp_cols[17*j+k] is bit j of partial product k
//   neg                  - neg[k]: row k is inverted, add 1 at bit 2k
//
// Handshake: a transfer happens on a clock edge where valid && ready are both
// high; valid never depends on ready, and the producer holds its data stable
// while valid is high and ready is low.
module booth_pp_gen import booth_pp_gen_pkg::*; (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  is_signed,
  input  logic [31:0]           x,
  input  logic [31:0]           y,
  input  logic                  cancel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PW*COL_W-1:0]   pp_cols,
  output logic [NPP-1:0]        neg
);

  logic resetn_seen;
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic in_fire;
  logic s2_load;

  logic        s1_signed;
  logic [31:0] s1_x;
  logic [31:0] s1_y;

  logic [XW-1:0]      x_e;
  logic [XW-1:0]      y_e;
  logic [XW:0]        y_grp;   // y_e with the implicit y_e[-1]=0 appended
  logic [PW-1:0]      rows [NPP];
  logic [NPP-1:0]     neg_d;
  logic [PW*COL_W-1:0] cols_d;

  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = resetn_seen && !cancel && (!s1_valid || s1_adv);
  assign in_fire   = in_valid && in_ready;
  assign s2_load   = s1_valid && s1_adv && !cancel;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resetn_seen <= 1'b0;
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
    end else begin
      resetn_seen <= 1'b1;
      if (cancel) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (in_fire)     s1_valid <= 1'b1;
        else if (s1_adv) s1_valid <= 1'b0;
        if (s2_load)        s2_valid <= 1'b1;
        else if (out_ready) s2_valid <= 1'b0;
      end
    end
  end

  // Data registers keep their contents on cancel; only the valid flags clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_signed <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      pp_cols   <= '0;
      neg       <= '0;
    end else begin
      if (in_fire) begin
        s1_signed <= is_signed;
        s1_x      <= x;
        s1_y      <= y;
      end
      if (s2_load) begin
        pp_cols <= cols_d;
        neg     <= neg_d;
      end
    end
  end

  assign x_e   = {{2{s1_signed & s1_x[31]}}, s1_x};
  assign y_e   = {{2{s1_signed & s1_y[31]}}, s1_y};
  assign y_grp = {y_e, 1'b0};

  for (genvar k = 0; k < NPP; k++) begin : g_row
    booth_sel #(.SHIFT(2 * k)) u_sel (
      .grp (y_grp[2*k+2 -: 3]),
      .x_e (x_e),
      .row (rows[k]),
      .neg (neg_d[k])
    );
  end

  for (genvar j = 0; j < PW; j++) begin : g_col
    for (genvar k = 0; k < NPP; k++) begin : g_bit
      assign cols_d[col_idx(j, k)] = rows[k][j];
    end
  end

endmodule

// File: tb/tb_booth_pp_gen.sv
// Directed and random bench for booth_pp_gen.
// Products are recovered from the column bus plus negate bits and compared
// against expected products queued when each request is accepted.
module tb_booth_pp_gen;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic          is_signed;
  logic [31:0]   x;
  logic [31:0]   y;
  logic          cancel;
  logic          out_valid;
  logic          out_ready;
  logic [1087:0] pp_cols;
  logic [16:0]   neg;

  int checks = 0;
  int errors = 0;

  logic [63:0]   exp_q[$];
  logic [63:0]   next_exp;
  logic          hold_pending = 1'b0;
  logic [1087:0] held_cols;
  logic [16:0]   held_neg;

  booth_pp_gen dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .x         (x),
    .y         (y),
    .cancel    (cancel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp_cols   (pp_cols),
    .neg       (neg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference product, mod 2^64.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae;
    logic [63:0] be;
    ae = s ? {{32{a[31]}}, a} : {32'b0, a};
    be = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ae * be;
  endfunction

  // Sum of all partial products plus their negate corrections.
  function automatic logic [63:0] pp_sum(input logic [1087:0] c, input logic [16:0] n);
    logic [63:0] s;
    logic [63:0] r;
    s = '0;
    for (int k = 0; k < 17; k++) begin
      r = '0;
      for (int j = 0; j < 64; j++) r[j] = c[17*j + k];
      s = s + r;
      if (n[k]) s = s + (64'd1 << (2 * k));
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Scoreboard / monitor: evaluates the cycle's handshakes, then advances one
  // clock. Returns at the following negedge.
  task automatic tick(output bit acc);
    logic [63:0] got;
    logic [63:0] e;
    #1;
    acc = in_valid && in_ready;
    if (hold_pending) begin
      checks++;
      assert (out_valid === 1'b1 && pp_cols === held_cols && neg === held_neg) else begin
        errors++;
        $error("FAIL hold_stable got valid=%b sum=%h exp valid=1 sum=%h",
               out_valid, pp_sum(pp_cols, neg), pp_sum(held_cols, held_neg));
      end
    end
    if (out_valid === 1'b1 && out_ready) begin
      got = pp_sum(pp_cols, neg);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out got %h exp none", got);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (got === e) else begin
          errors++;
          $error("FAIL product got %h exp %h", got, e);
        end
      end
    end
    hold_pending = out_valid && !out_ready && !cancel && resetn;
    held_cols    = pp_cols;
    held_neg     = neg;
    if (acc) exp_q.push_back(next_exp);
    if (cancel) exp_q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver tasks
  task automatic present(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    is_signed = s;
    x         = a;
    y         = b;
    next_exp  = e;
    in_valid  = 1'b1;
  endtask

  task automatic send(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    bit acc;
    bit done;
    done = 1'b0;
    present(s, a, b, e);
    for (int i = 0; i < 50 && !done; i++) begin
      tick(acc);
      done = acc;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(acc);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Send one request and check it surfaces on the second edge after accept.
  task automatic send_lat(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] e);
    bit acc;
    send(s, a, b, e);
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick(acc);
    chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
    drain();
  endtask

  initial begin
    bit acc;
    int idx;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [31:0] bx [4];
    logic [31:0] by [4];

    resetn    = 1'b0;
    in_valid  = 1'b0;
    is_signed = 1'b0;
    x         = '0;
    y         = '0;
    cancel    = 1'b0;
    out_ready = 1'b1;
    next_exp  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_neg", 64'(neg), 64'd0);
    chk("rst_cols_or", 64'(|pp_cols), 64'd0);
    resetn = 1'b1;
    #1;
    chk("rel_in_ready_pre", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("rel_in_ready_post", 64'(in_ready), 64'd1);

    // Basic unsigned and corner products
    out_ready = 1'b1;
    send_lat("u3x5", 1'b0, 32'd3, 32'd5, 64'd15);
    send_lat("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    send_lat("smax", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    send_lat("smin2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    send_lat("smin1", 1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);
    send_lat("uzero", 1'b0, 32'h1234_5678, 32'd0, 64'd0);

    // Backpressure: four back-to-back requests with the consumer stalled
    bx[0] = 32'd11;          by[0] = 32'd13;
    bx[1] = 32'hDEAD_BEEF;   by[1] = 32'h0000_1000;
    bx[2] = 32'hFFFF_FFF0;   by[2] = 32'h7FFF_FFFF;
    bx[3] = 32'h0001_0001;   by[3] = 32'hFFFF_FFFF;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) present(1'b1, bx[idx], by[idx], model(1'b1, bx[idx], by[idx]));
      else         in_valid = 1'b0;
      tick(acc);
      if (acc) idx++;
    end
    chk("bp_accepts", 64'(idx), 64'd2);
    #1;
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && idx < 4; c++) begin
      present(1'b1, bx[idx], by[idx], model(1'b1, bx[idx], by[idx]));
      tick(acc);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 64'(idx), 64'd4);
    drain();

    // Cancel with A in S2 and B in S1
    out_ready = 1'b1;
    send(1'b0, 32'd100, 32'd200, 64'd20000);
    send(1'b0, 32'd300, 32'd400, 64'd120000);
    chk("cxl_a_in_s2", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    cancel    = 1'b1;
    #1;
    chk("cxl_in_ready", 64'(in_ready), 64'd0);
    tick(acc);
    cancel    = 1'b0;
    out_ready = 1'b1;
    chk("cxl_out_valid_1", 64'(out_valid), 64'd0);
    tick(acc);
    chk("cxl_out_valid_2", 64'(out_valid), 64'd0);
    send_lat("cxl_c", 1'b1, 32'hFFFF_FFFD, 32'd21, 64'hFFFF_FFFF_FFFF_FFC1);

    // Reset with two requests in flight
    out_ready = 1'b0;
    send(1'b0, 32'd5, 32'd6, 64'd30);
    send(1'b0, 32'd7, 32'd8, 64'd56);
    chk("mrst_pre_valid", 64'(out_valid), 64'd1);
    resetn = 1'b0;
    #1;
    exp_q.delete();
    hold_pending = 1'b0;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_neg", 64'(neg), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd0);
    idle(2);
    resetn    = 1'b1;
    out_ready = 1'b1;
    idle(3);
    chk("mrst_no_stale", 64'(out_valid), 64'd0);
    send_lat("mrst_7xm9", 1'b1, 32'd7, 32'hFFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFC1);

    // Random requests under random backpressure
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom();
      rb = $urandom();
      if (i == 0) rb = 32'hAAAA_AAAA;
      if (i == 1) rb = 32'h5555_5555;
      present(rs, ra, rb, model(rs, ra, rb));
      acc = 1'b0;
      for (int c = 0; c < 50 && !acc; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick(acc);
      end
      chk("rand_accept", 64'(acc), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
